// File: rtl/comparador_pkg.sv
// Shared types and result codes for the serial magnitude comparator.
package comparador_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Result codes, laid out as {gt, eq, lt} so they drive the outputs directly
    localparam logic [2:0] R_NONE = 3'b000;
    localparam logic [2:0] R_GT   = 3'b100;
    localparam logic [2:0] R_EQ   = 3'b010;
    localparam logic [2:0] R_LT   = 3'b001;

endpackage : comparador_pkg

// File: rtl/comparador_serie_celda.sv
// One-bit compare cell: flags a difference and says whether bit a wins.
// inv flips the winner, used on the sign bit in two's-complement mode where
// a set bit means the more negative operand.
module celda_compara (
    input  logic a,
    input  logic b,
    input  logic inv,
    output logic dif,
    output logic a_may
);

    assign dif   = a ^ b;
    // Only meaningful when dif is set: then a=1 wins unless inverted
    assign a_may = a ^ inv;

endmodule : celda_compara

// File: rtl/comparador_serie.sv
// Serial MSB-first magnitude comparator with start/busy/done handshake.
// One operand bit per clock; optional early exit at the first differing bit.
module comparador_serie
    import comparador_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signo,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             signo_q, signo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       res_q, res_d;

    logic cell_dif;
    logic cell_a_may;
    logic cell_inv;

    // Sign inversion applies only to the first bit examined (the sign bit)
    assign cell_inv = signo_q & (cnt_q == '0);

    celda_compara u_celda (
        .a     (a_q[WIDTH-1]),
        .b     (b_q[WIDTH-1]),
        .inv   (cell_inv),
        .dif   (cell_dif),
        .a_may (cell_a_may)
    );

    // State, operand shifters, counter and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            signo_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= R_NONE;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            signo_q <= signo_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    // Next-state logic: capture on accepted start, then one bit per cycle
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        signo_d = signo_q;
        cnt_d   = cnt_q;
        res_d   = res_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SHIFT;
                    a_d     = A;
                    b_d     = B;
                    signo_d = signo;
                    cnt_d   = '0;
                    res_d   = R_NONE;
                end else begin
                    state_d = IDLE;
                end
            end

            SHIFT: begin
                // First difference decides; later bits are ignored once decided
                if (res_q == R_NONE && cell_dif) begin
                    res_d = cell_a_may ? R_GT : R_LT;
                end
                if (cnt_q == CNT_LAST && res_d == R_NONE) begin
                    res_d = R_EQ;
                end
                a_d = a_q << 1;
                b_d = b_q << 1;
                if ((EARLY_EXIT && res_d != R_NONE) || cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign busy         = (state_q == SHIFT);
    assign done         = (state_q == DONE);
    assign {gt, eq, lt} = res_q;

endmodule : comparador_serie

// File: tb/tb_comparador_serie.sv
// Directed bench for comparador_serie: WIDTH=4 with and without early exit,
// plus a WIDTH=16 early-exit instance sharing the same handshake inputs.
module tb_comparador_serie;

    localparam logic [2:0] X_GT = 3'b100;
    localparam logic [2:0] X_EQ = 3'b010;
    localparam logic [2:0] X_LT = 3'b001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signo = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [15:0] a16 = '0, b16 = '0;

    logic busy0, done0, gt0, eq0, lt0;
    logic busy1, done1, gt1, eq1, lt1;
    logic busy2, done2, gt2, eq2, lt2;

    int checks = 0;
    int failures = 0;

    // per-run observations
    int         nb0, nd0, nb1, nd1, nb2, nd2;
    logic [2:0] r0, r1, r2;

    always #5 clk = ~clk;

    comparador_serie #(.WIDTH(4), .EARLY_EXIT(1'b0)) dut_e0 (
        .clk(clk), .rst(rst), .start(start), .signo(signo), .A(a4), .B(b4),
        .busy(busy0), .done(done0), .gt(gt0), .eq(eq0), .lt(lt0)
    );

    comparador_serie #(.WIDTH(4), .EARLY_EXIT(1'b1)) dut_e1 (
        .clk(clk), .rst(rst), .start(start), .signo(signo), .A(a4), .B(b4),
        .busy(busy1), .done(done1), .gt(gt1), .eq(eq1), .lt(lt1)
    );

    comparador_serie #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut_w16 (
        .clk(clk), .rst(rst), .start(start), .signo(signo), .A(a16), .B(b16),
        .busy(busy2), .done(done2), .gt(gt2), .eq(eq2), .lt(lt2)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       s;
        int         busy_e0;
        int         busy_e1;
        logic [2:0] res;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse start with the given operands and watch 20 cycles. With interfere
    // set, start stays high one more cycle while the operands/sign change.
    task automatic run(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input bit interfere, input logic [15:0] ia, input logic [15:0] ib);
        @(negedge clk);
        a4 = a[3:0]; b4 = b[3:0]; a16 = a; b16 = b; signo = s; start = 1'b1;
        nb0 = 0; nd0 = 0; nb1 = 0; nd1 = 0; nb2 = 0; nd2 = 0;
        r0 = '0; r1 = '0; r2 = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy0) nb0++;
            if (done0) begin nd0++; r0 = {gt0, eq0, lt0}; end
            if (busy1) nb1++;
            if (done1) begin nd1++; r1 = {gt1, eq1, lt1}; end
            if (busy2) nb2++;
            if (done2) begin nd2++; r2 = {gt2, eq2, lt2}; end
            if (i == 0) begin
                if (interfere) begin
                    a4 = ia[3:0]; b4 = ib[3:0]; a16 = ia; b16 = ib; signo = ~s;
                end else begin
                    start = 1'b0;
                end
            end else if (i == 1) begin
                start = 1'b0;
            end
        end
    endtask

    task automatic check4(input string tag, input int eb0, input int eb1, input logic [2:0] er);
        check({tag, " e0 busy"}, nb0, eb0);
        check({tag, " e0 done"}, nd0, 1);
        check({tag, " e0 res"}, r0, er);
        check({tag, " e0 held"}, {gt0, eq0, lt0}, er);
        check({tag, " e1 busy"}, nb1, eb1);
        check({tag, " e1 done"}, nd1, 1);
        check({tag, " e1 res"}, r1, er);
        check({tag, " e1 held"}, {gt1, eq1, lt1}, er);
    endtask

    initial begin
        //          a      b      s     bE0 bE1 result
        vecs[0]  = '{4'd3,  4'd8,  1'b0, 4, 1, X_LT};
        vecs[1]  = '{4'd3,  4'd1,  1'b0, 4, 3, X_GT};
        vecs[2]  = '{4'd7,  4'd7,  1'b0, 4, 4, X_EQ};
        vecs[3]  = '{4'h8,  4'h3,  1'b1, 4, 1, X_LT};
        vecs[4]  = '{4'h8,  4'h3,  1'b0, 4, 1, X_GT};
        vecs[5]  = '{4'hF,  4'h1,  1'b1, 4, 1, X_LT};
        vecs[6]  = '{4'hE,  4'hF,  1'b1, 4, 4, X_LT};
        vecs[7]  = '{4'h5,  4'h6,  1'b1, 4, 3, X_LT};
        vecs[8]  = '{4'hF,  4'h0,  1'b0, 4, 1, X_GT};
        vecs[9]  = '{4'h0,  4'h0,  1'b1, 4, 4, X_EQ};
        vecs[10] = '{4'h7,  4'h8,  1'b1, 4, 1, X_GT};
        vecs[11] = '{4'h9,  4'h8,  1'b0, 4, 4, X_GT};

        // Reset state
        #2;
        check("reset e0 outs", {busy0, done0, gt0, eq0, lt0}, 5'b0);
        check("reset e1 outs", {busy1, done1, gt1, eq1, lt1}, 5'b0);
        check("reset w16 outs", {busy2, done2, gt2, eq2, lt2}, 5'b0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            run({12'd0, vecs[i].a}, {12'd0, vecs[i].b}, vecs[i].s, 1'b0, 16'd0, 16'd0);
            $display("vec %0d a=%h b=%h s=%0d e0 busy=%0d res=%b e1 busy=%0d res=%b",
                     i, vecs[i].a, vecs[i].b, vecs[i].s, nb0, r0, nb1, r1);
            check4($sformatf("vec%0d", i), vecs[i].busy_e0, vecs[i].busy_e1, vecs[i].res);
        end

        // Back-to-back equal compares with start held in DONE
        @(negedge clk);
        a4 = 4'd7; b4 = 4'd7; signo = 1'b0; start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            check($sformatf("b2b1 busy c%0d", k), {busy0, busy1}, 2'b11);
        end
        @(negedge clk);
        check("b2b1 done", {done0, done1}, 2'b11);
        check("b2b1 eq", {gt0, eq0, lt0, gt1, eq1, lt1}, {X_EQ, X_EQ});
        a4 = 4'd8; b4 = 4'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b2 no idle", {busy0, busy1}, 2'b11);
        check("b2b2 cleared", {gt0, eq0, lt0, gt1, eq1, lt1}, 6'b0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("b2b2 busy c%0d", k), {busy0, busy1}, 2'b11);
        end
        @(negedge clk);
        check("b2b2 done", {done0, done1}, 2'b11);
        check("b2b2 eq", {gt0, eq0, lt0, gt1, eq1, lt1}, {X_EQ, X_EQ});
        $display("b2b eq twice seen done0=%0d done1=%0d", done0, done1);
        repeat (20) @(negedge clk);

        // Start while busy is ignored, operand changes after capture ignored
        run(16'd5, 16'd9, 1'b0, 1'b1, 16'd9, 16'd5);
        $display("busy-start e0 busy=%0d res=%b e1 busy=%0d res=%b", nb0, r0, nb1, r1);
        check4("ignore", 4, 1, X_LT);

        // Asynchronous reset during bit-cycle 2
        @(negedge clk);
        a4 = 4'd3; b4 = 4'd8; signo = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("prerst e0 busy", busy0, 1'b1);
        check("prerst e1 res", {gt1, eq1, lt1}, X_LT);
        rst = 1'b1;
        #1;
        check("rst e0 outs", {busy0, done0, gt0, eq0, lt0}, 5'b0);
        check("rst e1 outs", {busy1, done1, gt1, eq1, lt1}, 5'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("postrst e0 idle", {busy0, done0, gt0, eq0, lt0}, 5'b0);
        $display("async reset mid-compare outputs cleared");
        run(16'd3, 16'd8, 1'b0, 1'b0, 16'd0, 16'd0);
        $display("after reset e0 busy=%0d res=%b e1 busy=%0d res=%b", nb0, r0, nb1, r1);
        check4("afterrst", 4, 1, X_LT);

        // WIDTH=16 cases
        run(16'h8000, 16'h7FFF, 1'b0, 1'b0, 16'd0, 16'd0);
        $display("w16 8000 vs 7FFF unsigned busy=%0d res=%b", nb2, r2);
        check("w16 u busy", nb2, 1);
        check("w16 u done", nd2, 1);
        check("w16 u res", r2, X_GT);
        run(16'h8000, 16'h7FFF, 1'b1, 1'b0, 16'd0, 16'd0);
        $display("w16 8000 vs 7FFF signed busy=%0d res=%b", nb2, r2);
        check("w16 s busy", nb2, 1);
        check("w16 s res", r2, X_LT);
        run(16'hA5A5, 16'hA5A5, 1'b1, 1'b0, 16'd0, 16'd0);
        $display("w16 A5A5 vs A5A5 busy=%0d res=%b", nb2, r2);
        check("w16 eq busy", nb2, 16);
        check("w16 eq res", r2, X_EQ);
        run(16'h1234, 16'h1235, 1'b0, 1'b0, 16'd0, 16'd0);
        $display("w16 1234 vs 1235 busy=%0d res=%b", nb2, r2);
        check("w16 lsb busy", nb2, 16);
        check("w16 lsb res", r2, X_LT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_comparador_serie
